// File: rtl/affhl_pkg.sv
// Shared defaults and state type for the fixed-point block accumulator.
package affhl_pkg;

  localparam int unsigned FixedSizeDef      = 64;
  localparam int unsigned RadixPointSizeDef = 6;
  localparam int unsigned LengthSizeDef     = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

endpackage

// File: rtl/fixed_sat_add.sv
// Signed W-bit adder; saturates and flags overflow when FIXED_ACCUMULATOR_SAT_EN is defined,
// otherwise wraps two's-complement with overflow tied low.
module fixed_sat_add #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         overflow
);

`ifdef FIXED_ACCUMULATOR_SAT_EN
  logic [W:0] wide;
  logic       ovf;

  assign wide = {a[W-1], a} + {b[W-1], b};
  // Sign-extension bit disagreeing with the result MSB means the W-bit range was left.
  assign ovf  = wide[W] ^ wide[W-1];

  always_comb begin
    sum = wide[W-1:0];
    if (ovf) begin
      sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  assign overflow = ovf;
`else
  // Dropping the extension bit of the wide sum is plain W-bit wrap.
  assign sum      = a + b;
  assign overflow = 1'b0;
`endif

endmodule

// File: rtl/fixed_accumulator.sv
// Sums blocks of InLength signed fixed-point samples and holds the result for the consumer.
// Saturating arithmetic is enabled by FIXED_ACCUMULATOR_SAT_EN (see fixed_sat_add).
module fixed_accumulator
  import affhl_pkg::*;
#(
  parameter int unsigned FIXEDSIZE      = FixedSizeDef,
  parameter int unsigned RADIXPOINTSIZE = RadixPointSizeDef,
  parameter int unsigned LENGTHSIZE     = LengthSizeDef
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [FIXEDSIZE-1:0]      InFixed,
  input  logic [RADIXPOINTSIZE-1:0] InRadixPoint,
  input  logic [LENGTHSIZE-1:0]     InLength,
  input  logic                      InValid,
  output logic                      InReady,
  output logic [FIXEDSIZE-1:0]      OutFixed,
  output logic [RADIXPOINTSIZE-1:0] OutRadixPoint,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic                      OutOverflow,
  output logic                      OutRadixErr
);

  localparam int unsigned CntW = LENGTHSIZE + 1;

  state_e                    state_q, state_d;
  logic [FIXEDSIZE-1:0]      acc_q, acc_d;
  logic [CntW-1:0]           count_q, count_d;
  logic [CntW-1:0]           len_q, len_d;
  logic [RADIXPOINTSIZE-1:0] radix_q, radix_d;
  logic                      ovf_q, ovf_d;
  logic                      rerr_q, rerr_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;

  logic                      in_xfer, out_xfer;
  logic [FIXEDSIZE-1:0]      add_a, add_sum;
  logic                      add_ovf;
  logic [CntW-1:0]           len_in, count_inc;

  assign in_xfer   = InValid & in_ready_q;
  assign out_xfer  = out_valid_q & OutReady;
  assign add_a     = (state_q == StIdle) ? '0 : acc_q;
  // A zero length field encodes the full 2**LENGTHSIZE block.
  assign len_in    = (InLength == '0) ? (CntW'(1) << LENGTHSIZE) : {1'b0, InLength};
  assign count_inc = count_q + CntW'(1);

  fixed_sat_add #(
    .W (FIXEDSIZE)
  ) u_add (
    .a        (add_a),
    .b        (InFixed),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    len_d   = len_q;
    radix_d = radix_q;
    ovf_d   = ovf_q;
    rerr_d  = rerr_q;
    unique case (state_q)
      StIdle: begin
        if (in_xfer) begin
          acc_d   = add_sum;
          radix_d = InRadixPoint;
          len_d   = len_in;
          count_d = CntW'(1);
          ovf_d   = 1'b0;
          rerr_d  = 1'b0;
          state_d = (len_in == CntW'(1)) ? StHold : StAccum;
        end
      end
      StAccum: begin
        if (in_xfer) begin
          acc_d   = add_sum;
          count_d = count_inc;
          ovf_d   = ovf_q | add_ovf;
          rerr_d  = rerr_q | (InRadixPoint != radix_q);
          state_d = (count_inc == len_q) ? StHold : StAccum;
        end
      end
      StHold: begin
        if (out_xfer) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    in_ready_d  = (state_d != StHold);
    out_valid_d = (state_d == StHold);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      count_q     <= '0;
      len_q       <= '0;
      radix_q     <= '0;
      ovf_q       <= 1'b0;
      rerr_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      len_q       <= len_d;
      radix_q     <= radix_d;
      ovf_q       <= ovf_d;
      rerr_q      <= rerr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign InReady       = in_ready_q;
  assign OutValid      = out_valid_q;
  assign OutFixed      = acc_q;
  assign OutRadixPoint = radix_q;
  assign OutOverflow   = ovf_q;
  assign OutRadixErr   = rerr_q;

endmodule

// File: tb/tb_fixed_accumulator.sv
// Directed bench for fixed_accumulator at FIXEDSIZE=16, LENGTHSIZE=4.
module tb_fixed_accumulator;

  localparam int unsigned FW = 16;
  localparam int unsigned RW = 6;
  localparam int unsigned LW = 4;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [FW-1:0] InFixed;
  logic [RW-1:0] InRadixPoint;
  logic [LW-1:0] InLength;
  logic          InValid;
  logic          InReady;
  logic [FW-1:0] OutFixed;
  logic [RW-1:0] OutRadixPoint;
  logic          OutValid;
  logic          OutReady;
  logic          OutOverflow;
  logic          OutRadixErr;

  int vectors     = 0;
  int miscompares = 0;

  fixed_accumulator #(
    .FIXEDSIZE      (FW),
    .RADIXPOINTSIZE (RW),
    .LENGTHSIZE     (LW)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .InFixed       (InFixed),
    .InRadixPoint  (InRadixPoint),
    .InLength      (InLength),
    .InValid       (InValid),
    .InReady       (InReady),
    .OutFixed      (OutFixed),
    .OutRadixPoint (OutRadixPoint),
    .OutValid      (OutValid),
    .OutReady      (OutReady),
    .OutOverflow   (OutOverflow),
    .OutRadixErr   (OutRadixErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One upstream transfer: inputs set at a falling edge, taken on the next rising edge.
  task automatic xfer(input logic [FW-1:0] d, input logic [RW-1:0] rp, input logic [LW-1:0] len);
    check("in_ready_before_xfer", 64'(InReady), 64'd1);
    InFixed      = d;
    InRadixPoint = rp;
    InLength     = len;
    InValid      = 1'b1;
    @(negedge Clk);
    InValid      = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [FW-1:0] f, input logic [RW-1:0] rp,
                           input logic ovf, input logic rerr);
    check({tag, "_valid"}, 64'(OutValid), 64'd1);
    check({tag, "_ready"}, 64'(InReady), 64'd0);
    check({tag, "_fixed"}, 64'(OutFixed), 64'(f));
    check({tag, "_radix"}, 64'(OutRadixPoint), 64'(rp));
    check({tag, "_ovf"}, 64'(OutOverflow), 64'(ovf));
    check({tag, "_rerr"}, 64'(OutRadixErr), 64'(rerr));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 64'(OutValid), 64'd0);
    check({tag, "_ready"}, 64'(InReady), 64'd1);
    check({tag, "_fixed"}, 64'(OutFixed), 64'd0);
    check({tag, "_radix"}, 64'(OutRadixPoint), 64'd0);
    check({tag, "_ovf"}, 64'(OutOverflow), 64'd0);
    check({tag, "_rerr"}, 64'(OutRadixErr), 64'd0);
  endtask

  initial begin
    Rst = 1'b1; InFixed = '0; InRadixPoint = '0; InLength = '0; InValid = 1'b0; OutReady = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    check_reset("reset");

    // Basic 3-sample block, radix 4.
    OutReady = 1'b1;
    xfer(16'd5, 6'd4, 4'd3);
    xfer(16'hFFFE, 6'd4, 4'd3);
    check("basic_mid_valid", 64'(OutValid), 64'd0);
    xfer(16'd7, 6'd4, 4'd3);
    check_out("basic", 16'd10, 6'd4, 1'b0, 1'b0);
    @(negedge Clk);
    check("basic_after_valid", 64'(OutValid), 64'd0);
    check("basic_after_ready", 64'(InReady), 64'd1);

    // Positive overflow.
    xfer(16'h7000, 6'd0, 4'd2);
    xfer(16'h2000, 6'd0, 4'd2);
`ifdef FIXED_ACCUMULATOR_SAT_EN
    check_out("pos_ovf", 16'h7FFF, 6'd0, 1'b1, 1'b0);
`else
    check_out("pos_ovf", 16'h9000, 6'd0, 1'b0, 1'b0);
`endif
    @(negedge Clk);

    // Negative overflow: -0x7000 + -0x2000.
    xfer(16'h9000, 6'd1, 4'd2);
    xfer(16'hE000, 6'd1, 4'd2);
`ifdef FIXED_ACCUMULATOR_SAT_EN
    check_out("neg_ovf", 16'h8000, 6'd1, 1'b1, 1'b0);
`else
    check_out("neg_ovf", 16'h7000, 6'd1, 1'b0, 1'b0);
`endif
    @(negedge Clk);

    // -5 + -7: no overflow, sticky flag cleared by new block.
    xfer(16'hFFFB, 6'd1, 4'd2);
    xfer(16'hFFF9, 6'd1, 4'd2);
    check_out("neg_sum", 16'hFFF4, 6'd1, 1'b0, 1'b0);
    @(negedge Clk);

    // Length 1 with back-pressure; an offered sample during HOLD must be ignored.
    OutReady = 1'b0;
    xfer(16'h1234, 6'd2, 4'd1);
    InFixed = 16'h5555; InRadixPoint = 6'd9; InValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_out("hold", 16'h1234, 6'd2, 1'b0, 1'b0);
      @(negedge Clk);
    end
    OutReady = 1'b1;
    InValid  = 1'b0;
    @(negedge Clk);
    check("hold_release_valid", 64'(OutValid), 64'd0);
    check("hold_release_ready", 64'(InReady), 64'd1);
    check("hold_release_fixed", 64'(OutFixed), 64'h1234);

    // Length 0 = 16 samples, with a stall and a changed length mid-block.
    for (int i = 0; i < 16; i++) begin
      xfer(16'd1, 6'd0, 4'd0);
      if (i == 7) begin
        InLength = 4'd5;
        @(negedge Clk);
        check("len16_stall_fixed", 64'(OutFixed), 64'd8);
      end
      if (i == 14) check("len16_15_valid", 64'(OutValid), 64'd0);
    end
    check_out("len16", 16'd16, 6'd0, 1'b0, 1'b0);
    @(negedge Clk);

    // Reset mid-block with a concurrent transfer.
    xfer(16'd3, 6'd0, 4'd4);
    xfer(16'd4, 6'd0, 4'd4);
    Rst = 1'b1; InFixed = 16'd9; InValid = 1'b1;
    @(negedge Clk);
    Rst = 1'b0; InValid = 1'b0;
    check_reset("rst_mid");

    // Radix mismatch block, then reset while holding the result.
    OutReady = 1'b0;
    xfer(16'd100, 6'd3, 4'd2);
    xfer(16'd23, 6'd5, 4'd2);
    check_out("rerr", 16'd123, 6'd3, 1'b0, 1'b1);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check_reset("rst_hold");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fixed_accumulator.md
FIXED_ACCUMULATOR -- requirements
Module: fixed_accumulator

Interface
REQ-001 SHALL have parameter FIXEDSIZE, default 64, the width of the signed fixed-point sample and result.
REQ-002 SHALL have parameter RADIXPOINTSIZE, default 6, the width of the radix-point field.
REQ-003 SHALL have parameter LENGTHSIZE, default 8, the width of the block-length field.
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port InFixed, input, FIXEDSIZE bits: signed two's-complement sample.
REQ-007 SHALL have port InRadixPoint, input, RADIXPOINTSIZE bits: radix position from the right.
REQ-008 SHALL have port InLength, input, LENGTHSIZE bits: samples per block; 0 means 2**LENGTHSIZE.
REQ-009 SHALL have ports InValid (input, 1 bit) and InReady (output, 1 bit): the upstream handshake.
REQ-010 SHALL have port OutFixed, output, FIXEDSIZE bits: the signed block sum.
REQ-011 SHALL have port OutRadixPoint, output, RADIXPOINTSIZE bits: the radix point of OutFixed.
REQ-012 SHALL have ports OutValid (output, 1 bit) and OutReady (input, 1 bit): the downstream handshake toward the fixed-to-float converter.
REQ-013 SHALL have port OutOverflow, output, 1 bit: the sum saturated during this block.
REQ-014 SHALL have port OutRadixErr, output, 1 bit: a sample's radix point differed from the first sample's.

Function
REQ-015 A transfer SHALL occur on a cycle with InValid=1 and InReady=1; output transfer on OutValid=1 and OutReady=1.
REQ-016 SHALL use states IDLE, ACCUM and HOLD; InReady=1 in IDLE and ACCUM, 0 in HOLD; OutValid=1 only in HOLD.
REQ-017 In IDLE, the first transfer SHALL:
- load Acc=InFixed;
- latch InRadixPoint and InLength;
- set Count=1;
- clear both flags.
REQ-018 Each transfer in ACCUM SHALL set Acc=Acc+InFixed and Count=Count+1.
REQ-019 The next state after each transfer SHALL be HOLD when Count reaches the latched length (including length 1 from IDLE), otherwise ACCUM.
REQ-020 Count SHALL be LENGTHSIZE+1 bits wide so that a length of 2**LENGTHSIZE does not wrap.
REQ-021 Latency: OutValid SHALL rise on the cycle after the final transfer; OutFixed, OutRadixPoint and the flags stay stable throughout HOLD.
REQ-022 An output transfer SHALL return the state to IDLE; InReady stays 0 in the handshake cycle, so the next block starts one cycle later at earliest.
REQ-023 OutValid SHALL never drop in HOLD without OutReady=1 (no retraction).
REQ-024 In ACCUM, a transfer whose InRadixPoint differs from the latched value SHALL set OutRadixErr (sticky for the block); the sample is still added unaligned.
REQ-025 InValid=0 in ACCUM SHALL hold all state; InLength and InRadixPoint SHALL be ignored outside the first transfer of a block.
REQ-026 Addition SHALL be computed in FIXEDSIZE+1 bits and then reduced per REQ-029/REQ-030.

Reset
REQ-027 Rst=1 SHALL force IDLE on the next edge: Acc=0, Count=0, OutFixed=0, OutRadixPoint=0, OutValid=0, OutOverflow=0, OutRadixErr=0, InReady=1 from the following cycle.
REQ-028 Rst SHALL take priority over any concurrent transfer; a partial block or pending HOLD result is discarded.

Configuration
REQ-029 With macro FIXED_ACCUMULATOR_SAT_EN defined:
- an overflowing sum SHALL clamp to +(2**(FIXEDSIZE-1)-1) or -(2**(FIXEDSIZE-1));
- OutOverflow SHALL be set (sticky for the block).
REQ-030 Without FIXED_ACCUMULATOR_SAT_EN:
- the sum SHALL wrap two's-complement;
- OutOverflow SHALL be constant 0.

Structure
REQ-031 Package affhl_pkg SHALL hold:
- the FIXEDSIZE, RADIXPOINTSIZE and LENGTHSIZE defaults;
- the state enumeration type (IDLE/ACCUM/HOLD).
REQ-032 Saturating addition SHALL be a sub-module fixed_sat_add (operands a and b, sum, overflow); fixed_accumulator instantiates it once.

Verification
REQ-033 Run the bench with FIXEDSIZE=16, LENGTHSIZE=4 and the macro defined unless stated otherwise.
REQ-034 InLength=3, samples 5, -2, 7, radix 4, OutReady=1 -> OutValid one cycle after the 3rd transfer; OutFixed=10, OutRadixPoint=4; both flags 0.
REQ-035 InLength=2, samples 0x7000 and 0x2000 -> OutFixed=0x7FFF, OutOverflow=1; with the macro undefined -> OutFixed=0x9000, OutOverflow=0.
REQ-036 InLength=1, OutReady=0 for 5 cycles -> OutValid held, InReady=0, output stable; OutReady=1 -> IDLE next cycle, InReady=1.
REQ-037 InLength=0, 16 samples of 1 -> OutFixed=16.
REQ-038 Rst asserted after 2 of 4 samples -> all outputs reach reset values; a new 2-sample block (radix 3, then radix 5) -> correct sum, OutRadixErr=1.
